enable_scheduler: RTL and testbench

Four-channel tick scheduler built around a shared clock-enable prescaler. One internal prescaler produces a base tick every PRESCALE+1 cycles of clock_5. Per-channel programmable down-counters divide the base tick further, and a round-robin arbiter delivers expiries as single-cycle enable pulses, at most one per cycle. The block sits between the clock domain and the slow-rate consumers (blinkers, display refresh, debouncers) so that all of them share one divider chain.

---
 rtl/enable_scheduler_if.sv | 24 ++
 rtl/enable_scheduler.sv | 114 +++++++++++
 tb/tb_enable_scheduler.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/enable_scheduler_if.sv
// Configuration and tick-delivery bundle for enable_scheduler.
// The slave side is the scheduler; the master side is the host or consumer logic.
interface enable_scheduler_if #(
    parameter int CNT_W = 16
) ();
    logic             cfg_we;
    logic [1:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_period;
    logic [3:0]       ch_en;
    logic [3:0]       tick_out;
    logic [3:0]       pending;
    logic [3:0]       missed;
    logic             busy;

    modport master (
        output cfg_we, cfg_ch, cfg_period, ch_en,
        input  tick_out, pending, missed, busy
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_period, ch_en,
        output tick_out, pending, missed, busy
    );
endinterface

// File: rtl/enable_scheduler.sv
// Four-channel tick scheduler: a shared prescaler, per-channel period down-counters,
// and a round-robin arbiter that emits at most one single-cycle enable pulse per cycle.
module enable_scheduler #(
    parameter int unsigned PRESCALE = 5,
    parameter int          CNT_W    = 16
) (
    input logic              clock_5,
    input logic              reset,
    enable_scheduler_if.slave bus
);
    logic [31:0]      presc_cnt;
    logic             base_tick;
    logic [CNT_W-1:0] period  [4];
    logic [CNT_W-1:0] counter [4];
    logic [3:0]       pending_p0;
    logic [3:0]       missed_p0;
    logic [3:0]       tick_p1;
    logic [1:0]       last_grant;
    logic [3:0]       cfg_hit;
    logic [3:0]       expire;
    logic [3:0]       eligible;
    logic [3:0]       grant_oh;
    logic [1:0]       grant_idx;
    logic [1:0]       cand;
    logic             vld_p0;

    // stage 0: prescaler, channel counters and expiry flags
    assign base_tick = (presc_cnt == PRESCALE);

    always_ff @(posedge clock_5) begin
        if (!reset) begin
            presc_cnt <= '0;
        end else if (base_tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 32'd1;
        end
    end

    always_comb begin
        cfg_hit = '0;
        expire  = '0;
        for (int c = 0; c < 4; c++) begin
            cfg_hit[c] = bus.cfg_we && (bus.cfg_ch == 2'(c));
            expire[c]  = bus.ch_en[c] && base_tick && (counter[c] == '0);
        end
    end

    // A channel being rewritten or disabled this cycle must not produce a tick.
    assign eligible = pending_p0 & bus.ch_en & ~cfg_hit;

    // Scan from the farthest candidate to the nearest so the nearest one wins.
    always_comb begin
        vld_p0    = 1'b0;
        grant_idx = last_grant;
        cand      = '0;
        for (int i = 4; i >= 1; i--) begin
            cand = last_grant + 2'(i);
            if (eligible[cand]) begin
                vld_p0    = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign grant_oh = vld_p0 ? (4'b0001 << grant_idx) : 4'b0000;

    // stage 1: grant registered into tick_out, pending/missed bookkeeping
    always_ff @(posedge clock_5) begin
        if (!reset) begin
            for (int c = 0; c < 4; c++) begin
                period[c]  <= '0;
                counter[c] <= '0;
            end
            pending_p0 <= '0;
            missed_p0  <= '0;
            tick_p1    <= '0;
            last_grant <= 2'd3;
        end else begin
            tick_p1 <= grant_oh;
            if (vld_p0) begin
                last_grant <= grant_idx;
            end
            for (int c = 0; c < 4; c++) begin
                if (cfg_hit[c]) begin
                    period[c]     <= bus.cfg_period;
                    counter[c]    <= bus.cfg_period;
                    pending_p0[c] <= 1'b0;
                    missed_p0[c]  <= 1'b0;
                end else if (!bus.ch_en[c]) begin
                    counter[c]    <= period[c];
                    pending_p0[c] <= 1'b0;
                end else begin
                    if (base_tick) begin
                        counter[c] <= (counter[c] == '0) ? period[c] : counter[c] - 1'b1;
                    end
                    if (expire[c]) begin
                        pending_p0[c] <= 1'b1;
                        if (pending_p0[c] && !grant_oh[c]) begin
                            missed_p0[c] <= 1'b1;
                        end
                    end else if (grant_oh[c]) begin
                        pending_p0[c] <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.tick_out = tick_p1;
    assign bus.pending  = pending_p0;
    assign bus.missed   = missed_p0;
    assign bus.busy     = |pending_p0;
endmodule

// File: tb/tb_enable_scheduler.sv
// Scoreboard bench for enable_scheduler: one instance at PRESCALE=5, one at PRESCALE=0.
module tb_enable_scheduler;
    localparam int CNT_W = 16;

    logic clock_5 = 1'b0;
    logic reset   = 1'b0;

    always #5 clock_5 = ~clock_5;

    enable_scheduler_if #(.CNT_W(CNT_W)) bus_a ();
    enable_scheduler_if #(.CNT_W(CNT_W)) bus_b ();

    enable_scheduler #(.PRESCALE(5), .CNT_W(CNT_W)) dut_a (
        .clock_5 (clock_5),
        .reset   (reset),
        .bus     (bus_a.slave)
    );

    enable_scheduler #(.PRESCALE(0), .CNT_W(CNT_W)) dut_b (
        .clock_5 (clock_5),
        .reset   (reset),
        .bus     (bus_b.slave)
    );

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected tick_out of {dut_b, dut_a} in cycle n after reset release.
    function automatic logic [7:0] exp_ticks(input int ph, input int n);
        logic [3:0] a;
        logic [3:0] b;
        a = 4'b0000;
        b = 4'b0000;
        case (ph)
            1: if (n >= 7 && (n - 7) % 6 == 0) a = 4'b0001;
            2: if (n >= 19 && (n - 19) % 18 == 0) a = 4'b0010;
            3: begin
                if (n >= 7 && (n - 7) % 6 < 4) a = 4'b0001 << ((n - 7) % 6);
                if (n >= 2) b = 4'b0001 << ((n - 2) % 4);
            end
            5: if (n == 31) a = 4'b0001;
            6: if (n >= 14 && (n - 14) % 6 < 4) a = 4'b0001 << ((n - 14) % 6);
            default: ;
        endcase
        return {b, a};
    endfunction

    task automatic idle_inputs();
        bus_a.cfg_we     = 1'b0;
        bus_a.cfg_ch     = 2'd0;
        bus_a.cfg_period = '0;
        bus_a.ch_en      = 4'b0000;
        bus_b.cfg_we     = 1'b0;
        bus_b.cfg_ch     = 2'd0;
        bus_b.cfg_period = '0;
        bus_b.ch_en      = 4'b0000;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clock_5);
        #1;
        chk("rst_tick_a", bus_a.tick_out, 4'b0000);
        chk("rst_pend_a", bus_a.pending, 4'b0000);
        chk("rst_miss_a", bus_a.missed, 4'b0000);
        chk("rst_busy_a", bus_a.busy, 1'b0);
        chk("rst_tick_b", bus_b.tick_out, 4'b0000);
        chk("rst_pend_b", bus_b.pending, 4'b0000);
    endtask

    task automatic run_phase(input int ph, input int ncyc);
        for (int n = 1; n <= ncyc; n++) begin
            logic [7:0] e;
            exp_q.push_back(exp_ticks(ph, n));
            @(posedge clock_5);
            #1;
            e = exp_q.pop_front();
            chk($sformatf("p%0d_tick_a_c%0d", ph, n), bus_a.tick_out, e[3:0]);
            chk($sformatf("p%0d_tick_b_c%0d", ph, n), bus_b.tick_out, e[7:4]);
            chk($sformatf("p%0d_miss_a_c%0d", ph, n), bus_a.missed, 4'b0000);
            case (ph)
                1: chk($sformatf("p1_pend_a_c%0d", n), bus_a.pending,
                       (n >= 6 && (n - 6) % 6 == 0) ? 4'b0001 : 4'b0000);
                2: begin
                    if (n == 1) bus_a.cfg_we = 1'b0;
                    if (n == 18) chk("p2_pend_a_c18", bus_a.pending, 4'b0010);
                    if (n == 19) chk("p2_pend_a_c19", bus_a.pending, 4'b0000);
                end
                3: begin
                    if (n == 6)  chk("p3_pend_a_c6", bus_a.pending, 4'b1111);
                    if (n == 9)  chk("p3_pend_a_c9", bus_a.pending, 4'b1000);
                    if (n == 10) chk("p3_busy_a_c10", bus_a.busy, 1'b0);
                    chk($sformatf("p3_pend_b_c%0d", n), bus_b.pending, 4'b1111);
                    chk($sformatf("p3_busy_b_c%0d", n), bus_b.busy, 1'b1);
                    chk($sformatf("p3_miss_b_c%0d", n), bus_b.missed,
                        (n == 1) ? 4'b0000 : (n == 2) ? 4'b1110 : 4'b1111);
                end
                5: begin
                    if (n == 5) begin
                        bus_a.cfg_we     = 1'b1;
                        bus_a.cfg_ch     = 2'd0;
                        bus_a.cfg_period = 16'd3;
                    end
                    if (n == 6) begin
                        bus_a.cfg_we = 1'b0;
                        chk("p5_pend_a_c6", bus_a.pending, 4'b0000);
                    end
                    if (n == 30) chk("p5_pend_a_c30", bus_a.pending, 4'b0001);
                end
                6: begin
                    if (n == 1) bus_a.cfg_we = 1'b0;
                    if (n == 6) begin
                        chk("p6_pend_a_c6", bus_a.pending, 4'b0110);
                        chk("p6_busy_a_c6", bus_a.busy, 1'b1);
                        reset = 1'b0;
                    end
                    if (n == 7) begin
                        chk("p6_pend_a_c7", bus_a.pending, 4'b0000);
                        chk("p6_busy_a_c7", bus_a.busy, 1'b0);
                        reset       = 1'b1;
                        bus_a.ch_en = 4'b1111;
                    end
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        idle_inputs();

        do_reset();
        reset       = 1'b1;
        bus_a.ch_en = 4'b0001;
        run_phase(1, 30);

        do_reset();
        reset            = 1'b1;
        bus_a.cfg_we     = 1'b1;
        bus_a.cfg_ch     = 2'd1;
        bus_a.cfg_period = 16'd2;
        bus_a.ch_en      = 4'b0010;
        run_phase(2, 60);

        do_reset();
        reset       = 1'b1;
        bus_a.ch_en = 4'b1111;
        bus_b.ch_en = 4'b1111;
        run_phase(3, 24);

        do_reset();
        reset       = 1'b1;
        bus_a.ch_en = 4'b0001;
        run_phase(5, 40);

        do_reset();
        reset            = 1'b1;
        bus_a.cfg_we     = 1'b1;
        bus_a.cfg_ch     = 2'd3;
        bus_a.cfg_period = 16'd7;
        bus_a.ch_en      = 4'b0110;
        run_phase(6, 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
